// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared FSM state type, default geometry and tree-PLRU helpers
package cache_ctrl_pkg;
  localparam int WAYS = 8;
  localparam int SETS = 16;
  localparam int TAG_W = 12;
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);
  localparam int PLRU_W = WAYS - 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

  // Helpers work on a 16-way-sized tree; levels = log2(ways) limits the walk.
  function automatic logic [3:0] plru_victim(input logic [14:0] bits, input int levels);
    logic [3:0] node;
    logic [3:0] way;
    node = '0;
    way = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < levels) begin
        way = {way[2:0], bits[node]};
        node = {node[2:0], 1'b0} + 4'd1 + 4'(bits[node]);
      end
    end
    return way;
  endfunction

  function automatic logic [14:0] plru_touch(input logic [14:0] bits, input logic [3:0] way, input int levels);
    logic [3:0] node;
    logic [3:0] w;
    logic [14:0] nb;
    node = '0;
    nb = bits;
    w = way << (4 - levels);
    for (int l = 0; l < 4; l++) begin
      if (l < levels) begin
        nb[node] = ~w[3];
        node = {node[2:0], 1'b0} + 4'd1 + 4'(w[3]);
        w = {w[2:0], 1'b0};
      end
    end
    return nb;
  endfunction
endpackage

// File: rtl/way_select_ctrl_plru_tree.sv
// plru_tree: victim choice and post-touch bits for one set's PLRU tree
module plru_tree import cache_ctrl_pkg::*; #(
  parameter int WAYS = 8,
  localparam int WAY_W = $clog2(WAYS),
  localparam int PLRU_W = WAYS - 1
) (
  input  logic [PLRU_W-1:0] bits_i,
  input  logic [WAY_W-1:0]  touch_way_i,
  output logic [WAY_W-1:0]  victim_o,
  output logic [PLRU_W-1:0] next_o
);
  logic [14:0] bits_ext;
  logic [3:0]  victim_ext;
  logic [14:0] next_ext;
  always_comb begin
    bits_ext = 15'(bits_i);
    victim_ext = plru_victim(bits_ext, WAY_W);
    next_ext = plru_touch(bits_ext, 4'(touch_way_i), WAY_W);
  end
  assign victim_o = victim_ext[WAY_W-1:0];
  assign next_o = next_ext[PLRU_W-1:0];
endmodule

// File: rtl/way_select_ctrl.sv
// way_select_ctrl: one-at-a-time tag lookup, hit/victim way select and per-set tree PLRU
module way_select_ctrl import cache_ctrl_pkg::*; #(
  parameter int WAYS = 8,
  parameter int SETS = 16,
  parameter int TAG_W = 12,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS),
  localparam int PLRU_W = WAYS - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SET_W-1:0]      req_set,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic                  req_fill,
  input  logic [WAYS*TAG_W-1:0] way_tags,
  input  logic [WAYS-1:0]       way_valid,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [WAY_W-1:0]      resp_way,
  output logic                  err_multihit
);
  state_e state_q, state_d;
  logic [SET_W-1:0] set_q;
  logic [TAG_W-1:0] tag_q;
  logic fill_q, hit_q, err_q;
  logic [WAY_W-1:0] way_q;
  logic [PLRU_W-1:0] plru_q [SETS];
  logic match_any, multi, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, victim, lookup_way;
  logic [PLRU_W-1:0] plru_next;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i(plru_q[set_q]),
    .touch_way_i(way_q),
    .victim_o(victim),
    .next_o(plru_next)
  );

  // Descending scan so the lowest matching / invalid index wins.
  always_comb begin
    match_any = 1'b0;
    multi = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_valid[i] && way_tags[i*TAG_W +: TAG_W] == tag_q) begin
        multi = multi | match_any;
        match_any = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!way_valid[i]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    lookup_way = match_any ? hit_way : inv_any ? inv_way : victim;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && req_valid) state_d = LOOKUP;
    else if (state_q == LOOKUP) state_d = RESP;
    else if (state_q == RESP && resp_ready) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      set_q <= '0;
      tag_q <= '0;
      fill_q <= 1'b0;
      hit_q <= 1'b0;
      way_q <= '0;
      err_q <= 1'b0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        set_q <= req_set;
        tag_q <= req_tag;
        fill_q <= req_fill;
      end
      if (state_q == LOOKUP) begin
        hit_q <= match_any;
        way_q <= lookup_way;
        err_q <= err_q | multi;
      end
      if (state_q == RESP && resp_ready && (hit_q || fill_q)) plru_q[set_q] <= plru_next;
    end
  end

  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_hit = hit_q;
  assign resp_way = way_q;
  assign err_multihit = err_q;
endmodule

// File: tb/tb_way_select_ctrl.sv
// tb_way_select_ctrl: scoreboard bench for lookup, PLRU victim sequence, multihit, stall and reset
module tb_way_select_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_fill = 1'b0;
  logic resp_ready = 1'b0;
  logic [3:0] req_set = '0;
  logic [11:0] req_tag = '0;
  logic [95:0] way_tags = '0;
  logic [7:0] way_valid = '0;
  logic req_ready, resp_valid, resp_hit, err_multihit;
  logic [2:0] resp_way;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cur_exp;

  always #5 clk = ~clk;

  way_select_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag), .req_fill(req_fill),
    .way_tags(way_tags), .way_valid(way_valid), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
    .err_multihit(err_multihit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] tag_at(input int w, input logic [11:0] t);
    logic [95:0] v;
    v = '0;
    v[w*12 +: 12] = t;
    return v;
  endfunction

  task automatic start(input logic [3:0] s, input logic [11:0] t, input logic f,
                       input logic [95:0] tg, input logic [7:0] v, input int exp_hit, input int exp_way);
    int n;
    req_set = s;
    req_tag = t;
    req_fill = f;
    way_tags = tg;
    way_valid = v;
    req_valid = 1'b1;
    exp_q.push_back(exp_hit * 16 + exp_way);
    check("req_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("busy", 32'(req_ready), 0);
    n = 0;
    while (!resp_valid && n < 8) begin
      @(posedge clk);
      #1 n++;
    end
    check("lat", n, 1);
    cur_exp = exp_q.pop_front();
    check("hit", 32'(resp_hit), cur_exp / 16);
    check("way", 32'(resp_way), cur_exp % 16);
  endtask

  task automatic finish(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_rv", 32'(resp_valid), 1);
      check("hold_hit", 32'(resp_hit), cur_exp / 16);
      check("hold_way", 32'(resp_way), cur_exp % 16);
      check("hold_rdy", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("idle", 32'(req_ready), 1);
    check("rv_low", 32'(resp_valid), 0);
  endtask

  initial begin
    #12;
    check("rst_rdy", 32'(req_ready), 1);
    check("rst_rv", 32'(resp_valid), 0);
    check("rst_hit", 32'(resp_hit), 0);
    check("rst_way", 32'(resp_way), 0);
    check("rst_err", 32'(err_multihit), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(4'd0, 12'h0AB, 1'b0, '0, 8'h00, 0, 0);
    finish(0);
    start(4'd3, 12'h777, 1'b1, '0, 8'hFF, 0, 0);
    finish(0);
    start(4'd3, 12'h777, 1'b1, '0, 8'hFF, 0, 4);
    finish(0);
    start(4'd3, 12'h777, 1'b1, '0, 8'hFF, 0, 2);
    finish(0);
    start(4'd5, 12'h123, 1'b0, tag_at(5, 12'h123), 8'hFF, 1, 5);
    finish(0);
    start(4'd5, 12'h777, 1'b1, tag_at(5, 12'h123), 8'hFF, 0, 0);
    check("victim_low_half", 32'(resp_way < 3'd4), 1);
    finish(0);
    start(4'd7, 12'h055, 1'b0, tag_at(2, 12'h055) | tag_at(6, 12'h055), 8'hFF, 1, 2);
    check("err_set", 32'(err_multihit), 1);
    finish(0);
    start(4'd7, 12'h777, 1'b0, '0, 8'hFF, 0, 4);
    finish(0);
    start(4'd7, 12'h777, 1'b0, '0, 8'hFF, 0, 4);
    finish(0);
    check("err_sticky", 32'(err_multihit), 1);
    start(4'd0, 12'h0AB, 1'b0, tag_at(3, 12'h0AB), 8'h08, 1, 3);
    finish(3);
    start(4'd3, 12'h777, 1'b1, '0, 8'hFF, 0, 6);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rdy", 32'(req_ready), 1);
    check("mid_rv", 32'(resp_valid), 0);
    check("mid_hit", 32'(resp_hit), 0);
    check("mid_way", 32'(resp_way), 0);
    check("mid_err", 32'(err_multihit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(4'd3, 12'h777, 1'b1, '0, 8'hFF, 0, 0);
    finish(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp done");
    $fatal(1);
  end
endmodule
